// File: rtl/fifo_ser_pkg.sv
// ============================================================================
// Module      : fifo_ser_pkg
// Description : Shared state encoding and line-level constants for the
//               FIFO-fed UART-style transmit serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_ser_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_FETCH  = ST_FETCH,
    S_LOAD   = ST_LOAD,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/ser_bit_timer.sv
// ============================================================================
// Module      : ser_bit_timer
// Description : Baud counter; counts 0..CLKS_PER_BIT-1 while run is high and
//               flags the last cycle of each serial bit (and the one before).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!run || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick      = run && (r_count == C_LAST);
  // Lets the caller register a strobe that lands exactly on the last bit cycle.
  assign tick_next = run && (r_count == C_PRE);

endmodule

`default_nettype wire

// File: rtl/fifo_tx_serializer.sv
// ============================================================================
// Module      : fifo_tx_serializer
// Description : Pops words from a small FIFO and shifts each out as a frame:
//               start(0), DATA_W bits LSB first, optional even parity, stop(1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_tx_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BCW-1:0] C_BIT_LAST = BCW'(DATA_W - 1);

  ser_state_t        r_state;
  ser_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BCW-1:0]    r_bit_cnt;
  logic [BCW-1:0]    w_bit_cnt_nxt;
  logic              r_parity;
  logic              w_parity_nxt;
  logic              r_tx;
  logic              r_pop;
  logic              r_busy;
  logic              r_frame_done;
  logic              w_tx_nxt;
  logic              w_run;
  logic              w_tick;
  logic              w_tick_next;

  assign w_run = (r_state == S_START) || (r_state == S_DATA) ||
                 (r_state == S_PARITY) || (r_state == S_STOP);

  ser_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (w_run),
    .tick      (w_tick),
    .tick_next (w_tick_next)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_parity_nxt  = r_parity;
    w_tx_nxt      = STOP_BIT;

    case (r_state)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt   = fifo_data;
        w_parity_nxt  = ^fifo_data;
        w_bit_cnt_nxt = '0;
        w_state_nxt   = S_START;
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == C_BIT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx is a plain flop output.
    case (w_state_nxt)
      S_START:  w_tx_nxt = START_BIT;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_parity     <= 1'b0;
      r_tx         <= STOP_BIT;
      r_pop        <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_parity     <= w_parity_nxt;
      r_tx         <= w_tx_nxt;
      r_pop        <= (w_state_nxt == S_FETCH);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (r_state == S_STOP) && w_tick_next;
    end
  end

  assign tx         = r_tx;
  assign pop        = r_pop;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_tx_serializer.sv
// ============================================================================
// Module      : tb_fifo_tx_serializer
// Description : Directed plus randomized bench for fifo_tx_serializer; one
//               instance without parity, one with parity, each fed by a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;

  logic       fe0 = 1'b1, fe1 = 1'b1;
  logic [3:0] fdat0 = 4'h0, fdat1 = 4'h0;
  logic       pop0, tx0, busy0, fdone0;
  logic       pop1, tx1, busy1, fdone1;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int         pc0 = 0, pc1 = 0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_tx_serializer #(.DATA_W(4), .CLKS_PER_BIT(8), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fe0), .fifo_data(fdat0),
    .pop(pop0), .tx(tx0), .busy(busy0), .frame_done(fdone0)
  );

  fifo_tx_serializer #(.DATA_W(4), .CLKS_PER_BIT(8), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fe1), .fifo_data(fdat1),
    .pop(pop1), .tx(tx1), .busy(busy1), .frame_done(fdone1)
  );

  // FIFO models: data valid the cycle after pop, empty flag registered.
  always @(posedge clk) begin
    if (pop0) pc0 <= pc0 + 1;
    if (pop0 && q0.size() != 0) fdat0 <= q0.pop_front();
    fe0 <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (pop1) pc1 <= pc1 + 1;
    if (pop1 && q1.size() != 0) fdat1 <= q1.pop_front();
    fe1 <= (q1.size() == 0);
  end

  function automatic logic f_tx(input int s);
    return (s == 1) ? tx1 : tx0;
  endfunction

  function automatic logic f_busy(input int s);
    return (s == 1) ? busy1 : busy0;
  endfunction

  function automatic logic f_fdone(input int s);
    return (s == 1) ? fdone1 : fdone0;
  endfunction

  function automatic int f_pc(input int s);
    return (s == 1) ? pc1 : pc0;
  endfunction

  task automatic push(input int s, input logic [3:0] w);
    if (s == 1) q1.push_back(w);
    else        q0.push_back(w);
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the start bit, samples each bit mid-period, and checks the whole
  // frame against the word, plus frame_done placement and busy coverage.
  task automatic recv_frame(input int s, input logic [3:0] w, input int exp_gap,
                            input string tag);
    int         gap, nb, fd_at, fd_cnt, busy_lo;
    logic [7:0] got, exp;
    nb  = (s == 1) ? 7 : 6;
    gap = 0;
    while (f_tx(s) !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    if (f_tx(s) !== 1'b0) begin
      chk({31'd0, f_tx(s)}, 32'd0, {tag, " start-timeout"});
      return;
    end
    if (exp_gap >= 0) chk(gap, exp_gap, {tag, " gap"});
    got = '0; fd_at = -1; fd_cnt = 0; busy_lo = 0;
    for (int c = 0; c <= nb * 8; c++) begin
      if ((c % 8) == 4 && (c / 8) < nb) got[c/8] = f_tx(s);
      if (f_fdone(s) === 1'b1) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = c;
      end
      if (c < nb * 8 && f_busy(s) !== 1'b1) busy_lo++;
      if (c < nb * 8) @(negedge clk);
    end
    exp = '0;
    exp[0] = 1'b0;
    for (int i = 0; i < 4; i++) exp[1+i] = w[i];
    if (nb == 7) exp[5] = ^w;
    exp[nb-1] = 1'b1;
    chk({24'd0, got}, {24'd0, exp}, {tag, " bits"});
    chk(fd_at, nb * 8 - 1, {tag, " frame_done cycle"});
    chk(fd_cnt, 1, {tag, " frame_done width"});
    chk(busy_lo, 0, {tag, " busy low in frame"});
    chk({30'd0, f_tx(s), f_busy(s)}, 32'd2, {tag, " idle after stop"});
  endtask

  initial begin
    int         base, s, n;
    logic [3:0] ws[3];

    // Reset with FIFO empty
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk({28'd0, tx0, pop0, busy0, fdone0}, 32'h8, "reset dut0");
    chk({28'd0, tx1, pop1, busy1, fdone1}, 32'h8, "reset dut1");
    reset = 1'b1;
    tx_en = 1'b1;
    repeat (10) @(negedge clk);
    chk({28'd0, tx0, pop0, busy0, fdone0}, 32'h8, "idle empty dut0");
    chk(pc0 + pc1, 0, "no pop while empty");

    // Single word 4'hA, no parity; latency from push is 4 sampled idle cycles
    base = pc0;
    push(0, 4'hA);
    recv_frame(0, 4'hA, 4, "wordA");
    chk(pc0 - base, 1, "wordA pops");

    // Parity instance: 4'h7 -> parity 1, 4'h3 -> parity 0
    base = pc1;
    push(1, 4'h7);
    recv_frame(1, 4'h7, 4, "par7");
    push(1, 4'h3);
    recv_frame(1, 4'h3, 4, "par3");
    chk(pc1 - base, 2, "parity pops");

    // Three queued words go back-to-back with a 3-cycle idle gap
    base = pc0;
    push(0, 4'h1); push(0, 4'h2); push(0, 4'h3);
    recv_frame(0, 4'h1, 4, "b2b1");
    recv_frame(0, 4'h2, 3, "b2b2");
    recv_frame(0, 4'h3, 3, "b2b3");
    chk(pc0 - base, 3, "b2b pops");

    // tx_en dropped mid-DATA: current frame completes, next word held
    base = pc0;
    push(0, 4'h5); push(0, 4'h6);
    fork
      recv_frame(0, 4'h5, 4, "en5");
      begin
        repeat (20) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    chk(pc0 - base, 1, "held pops");
    chk({30'd0, tx0, busy0}, 32'd2, "held idle");
    tx_en = 1'b1;
    recv_frame(0, 4'h6, 3, "en6");
    chk(pc0 - base, 2, "resume pops");

    // Async reset in DATA bit 2 discards the popped word
    base = pc0;
    push(0, 4'hB); push(0, 4'h4);
    n = 0;
    while (tx0 !== 1'b0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    repeat (28) @(negedge clk);
    chk({31'd0, tx0}, 32'd0, "pre-reset bit2");
    #2 reset = 1'b0;
    #1 chk({28'd0, tx0, pop0, busy0, fdone0}, 32'h8, "async reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    recv_frame(0, 4'h4, 3, "post-reset");
    chk(pc0 - base, 2, "reset pops");

    // Randomized batches on either instance
    for (int r = 0; r < 6; r++) begin
      s = $urandom_range(0, 1);
      n = $urandom_range(1, 3);
      base = f_pc(s);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      for (int k = 0; k < n; k++) begin
        ws[k] = 4'($urandom_range(0, 15));
        push(s, ws[k]);
      end
      for (int k = 0; k < n; k++) begin
        recv_frame(s, ws[k], (k == 0) ? 4 : 3, $sformatf("rand%0d.%0d", r, k));
      end
      chk(f_pc(s) - base, n, $sformatf("rand%0d pops", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
